// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
// Purpose : Bundles the load handshake, shift enable and serial-side outputs
//           of the parallel-in / serial-out transmitter.
// Signals :
//   DIN        - parallel word offered by the producer
//   LOAD_VALID - producer holds DIN stable until LOAD_READY accepts it
//   LOAD_READY - transmitter can take a word this cycle (combinational)
//   EN         - shift enable; low stalls the serial stream
//   SO         - serial data bit
//   SO_VALID   - SO carries a real bit
//   SO_LAST    - SO carries the final bit of the current word
//   DONE       - one-cycle pulse after a word's final bit is consumed
//   BUSY       - transmitter is shifting a word
// Modports: master = producer/link side, slave = the serializer itself.
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] DIN;
  logic             LOAD_VALID;
  logic             LOAD_READY;
  logic             EN;
  logic             SO;
  logic             SO_VALID;
  logic             SO_LAST;
  logic             DONE;
  logic             BUSY;

  modport master (
    output DIN, LOAD_VALID, EN,
    input  LOAD_READY, SO, SO_VALID, SO_LAST, DONE, BUSY
  );

  modport slave (
    input  DIN, LOAD_VALID, EN,
    output LOAD_READY, SO, SO_VALID, SO_LAST, DONE, BUSY
  );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Purpose : Parallel-in, serial-out transmitter. A WIDTH-bit word is taken
//           through a valid/ready handshake and shifted out one bit per
//           enabled clock, with SO_VALID / SO_LAST framing and a DONE pulse
//           after the last bit. A new word can be accepted on the edge that
//           consumes the final bit, giving gap-free back-to-back frames.
// Ports   :
//   CLK   - clock, rising edge active
//   RST_N - asynchronous active-low reset; aborts any word in flight
//   bus   - piso_serializer_if slave modport (handshake, EN, serial outputs)
// Parameters:
//   WIDTH     - word length in bits (>= 2)
//   MSB_FIRST - 1: bit WIDTH-1 leaves first, 0: bit 0 leaves first
// ---------------------------------------------------------------------------
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_N,
  piso_serializer_if.slave   bus
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             done_q,  done_d;

  logic             last_bit;
  logic             load_ready;
  logic             accept;
  logic             out_bit;
  logic [WIDTH-1:0] shifted;

  // The counter holds the number of bits still to go after the one on SO,
  // so zero means SO currently shows the final bit of the word.
  assign last_bit   = (state_q == SHIFT) && (cnt_q == '0);
  assign load_ready = (state_q == IDLE) || (last_bit && bus.EN);
  assign accept     = bus.LOAD_VALID && load_ready;

  // Shift direction and output tap are fixed by MSB_FIRST; zeros fill in
  // from the far end so the register drains to zero by the end of a word.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
      assign out_bit = shreg_q[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
      assign out_bit = shreg_q[0];
    end
  endgenerate

  // Next-state logic: load on accept, shift on each enabled cycle, and on
  // the final enabled bit either reload (back-to-back) or return to IDLE.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          shreg_d = bus.DIN;
          cnt_d   = CNT_LOAD;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.EN) begin
          if (cnt_q == '0) begin
            done_d = 1'b1;
            if (accept) begin
              shreg_d = bus.DIN;
              cnt_d   = CNT_LOAD;
            end else begin
              shreg_d = shifted;
              state_d = IDLE;
            end
          end else begin
            shreg_d = shifted;
            cnt_d   = cnt_q - CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any partially sent word without DONE.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign bus.LOAD_READY = load_ready;
  assign bus.SO         = (state_q == SHIFT) ? out_bit : 1'b0;
  assign bus.SO_VALID   = (state_q == SHIFT);
  assign bus.SO_LAST    = last_bit;
  assign bus.DONE       = done_q;
  assign bus.BUSY       = (state_q == SHIFT);

endmodule
